// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (F fetch, L load/store), the data memory and dmem_arbiter.
// master: requester/memory side (drives requests and mem_rdata). slave: the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    // Port F: instruction fetch, read-only
    logic              f_valid;
    logic              f_ready;
    logic [31:0]       f_addr;
    logic              f_rsp_valid;
    logic [31:0]       f_rsp_rdata;

    // Port L: load/store, read/write
    logic              l_valid;
    logic              l_ready;
    logic [31:0]       l_addr;
    logic              l_we;
    logic [3:0]        l_be;
    logic [31:0]       l_wdata;
    logic              l_rsp_valid;
    logic [31:0]       l_rsp_rdata;

    // Single-port memory
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output f_valid, f_addr,
        input  f_ready, f_rsp_valid, f_rsp_rdata,
        output l_valid, l_addr, l_we, l_be, l_wdata,
        input  l_ready, l_rsp_valid, l_rsp_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  f_valid, f_addr,
        output f_ready, f_rsp_valid, f_rsp_rdata,
        input  l_valid, l_addr, l_we, l_be, l_wdata,
        output l_ready, l_rsp_valid, l_rsp_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between fetch (F) and load/store (L).
// Each access is a fixed IDLE -> ACCESS -> RESP sequence (one access per 3 cycles).
// Default arbitration: L has priority, F is forced through after STARVE_MAX contended losses.
// Build option: define DMEM_ARB_RR_EN to replace that with round-robin (no starvation counter).
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave arb
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e              state_q;
    logic                owner_l_q;
    logic                rsp_read_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [3:0]          mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                f_rsp_valid_q;
    logic                l_rsp_valid_q;

`ifdef DMEM_ARB_RR_EN
    logic                rr_last_l_q;   // 1: last grant went to L, 0: to F
`else
    logic [STARVE_W-1:0] starve_cnt_q;
`endif

    logic                grant_f_c;
    logic                grant_l_c;

    // Address bits outside the word index are intentionally ignored
    logic                unused_addr_c;
    assign unused_addr_c = ^{arb.f_addr[31:ADDR_W+2], arb.f_addr[1:0],
                             arb.l_addr[31:ADDR_W+2], arb.l_addr[1:0]};

    // Grant decision, only meaningful in IDLE and suppressed while reset is held
    always_comb begin
        grant_f_c = 1'b0;
        grant_l_c = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            if (arb.f_valid && arb.l_valid) begin
`ifdef DMEM_ARB_RR_EN
                if (rr_last_l_q) begin
                    grant_f_c = 1'b1;
                end else begin
                    grant_l_c = 1'b1;
                end
`else
                if (starve_cnt_q == STARVE_W'(STARVE_MAX)) begin
                    grant_f_c = 1'b1;
                end else begin
                    grant_l_c = 1'b1;
                end
`endif
            end else if (arb.f_valid) begin
                grant_f_c = 1'b1;
            end else if (arb.l_valid) begin
                grant_l_c = 1'b1;
            end
        end
    end

    // Transaction sequencer: latches the winner's request, drives the memory, returns the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_l_q     <= 1'b0;
            rsp_read_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= 4'b0000;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            f_rsp_valid_q <= 1'b0;
            l_rsp_valid_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_last_l_q   <= 1'b0;
`else
            starve_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_f_c || grant_l_c) begin
                        state_q   <= S_ACCESS;
                        mem_en_q  <= 1'b1;
                        owner_l_q <= grant_l_c;
                        if (grant_l_c) begin
                            mem_we_q    <= arb.l_we;
                            mem_be_q    <= arb.l_we ? arb.l_be : 4'b1111;
                            mem_addr_q  <= arb.l_addr[ADDR_W+1:2];
                            mem_wdata_q <= arb.l_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= 4'b1111;
                            mem_addr_q  <= arb.f_addr[ADDR_W+1:2];
                            mem_wdata_q <= '0;
                        end
`ifdef DMEM_ARB_RR_EN
                        rr_last_l_q <= grant_l_c;
`else
                        if (grant_f_c) begin
                            starve_cnt_q <= '0;
                        end else if (arb.f_valid &&
                                     starve_cnt_q != STARVE_W'(STARVE_MAX)) begin
                            starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
                        end
`endif
                    end
                end
                S_ACCESS: begin
                    state_q       <= S_RESP;
                    mem_en_q      <= 1'b0;
                    mem_we_q      <= 1'b0;
                    mem_be_q      <= 4'b0000;
                    mem_addr_q    <= '0;
                    mem_wdata_q   <= '0;
                    rsp_read_q    <= !mem_we_q;
                    f_rsp_valid_q <= !owner_l_q;
                    l_rsp_valid_q <= owner_l_q;
                end
                S_RESP: begin
                    state_q       <= S_IDLE;
                    f_rsp_valid_q <= 1'b0;
                    l_rsp_valid_q <= 1'b0;
                    rsp_read_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and memory outputs
    assign arb.f_ready   = grant_f_c;
    assign arb.l_ready   = grant_l_c;
    assign arb.mem_en    = mem_en_q;
    assign arb.mem_we    = mem_we_q;
    assign arb.mem_be    = mem_be_q;
    assign arb.mem_addr  = mem_addr_q;
    assign arb.mem_wdata = mem_wdata_q;

    // Responses: memory data arrives in RESP, routed only to the owner and only for reads
    assign arb.f_rsp_valid = f_rsp_valid_q;
    assign arb.l_rsp_valid = l_rsp_valid_q;
    assign arb.f_rsp_rdata = (f_rsp_valid_q && rsp_read_q) ? arb.mem_rdata : '0;
    assign arb.l_rsp_rdata = (l_rsp_valid_q && rsp_read_q) ? arb.mem_rdata : '0;

endmodule
